// File: rtl/rr_arbiter_4to2.sv
// Four-requester arbiter with a one-hot grant, a 2-bit grant index and a tenure hold limit.
// Round-robin or fixed-priority selection; there is one dead cycle between tenures.
module rr_arbiter_4to2 #(
  parameter int FIXED_PRIORITY = 0,
  parameter int HOLD_MAX       = 16,
  parameter int HOLD_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       no_req,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [1:0]        ptr, ptr_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [3:0]        grant_next;
  logic [1:0]        grant_id_next;
  logic              grant_valid_next, no_req_next, timeout_next;

  logic [1:0]        win_id;
  logic              owner_drop, hit_limit, release_now;

  // Winner selection: round-robin scans ptr upward mod 4, fixed priority picks the highest set bit
  always_comb begin
    win_id = 2'd0;
    if (FIXED_PRIORITY != 0) begin
      for (int k = 0; k < 4; k++) begin
        if (req[k]) begin
          win_id = 2'(k);
        end else begin
          win_id = win_id;
        end
      end
    end else begin
      // Descending scan so the earliest position after ptr is written last
      for (int k = 3; k >= 0; k--) begin
        if (req[ptr + 2'(k)]) begin
          win_id = ptr + 2'(k);
        end else begin
          win_id = win_id;
        end
      end
    end
  end

  assign owner_drop  = ~req[grant_id];
  assign hit_limit   = (HOLD_MAX != 0) && (hold_cnt == HOLD_W'(HOLD_MAX));
  assign release_now = done | owner_drop | hit_limit;

  // Next-state and next-output logic
  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    hold_cnt_next    = hold_cnt;
    grant_next       = grant;
    grant_id_next    = grant_id;
    grant_valid_next = grant_valid;
    no_req_next      = 1'b0;
    timeout_next     = 1'b0;
    case (state)
      IDLE: begin
        if (req != 4'd0) begin
          state_next       = GRANT;
          grant_next       = 4'd1 << win_id;
          grant_id_next    = win_id;
          grant_valid_next = 1'b1;
          hold_cnt_next    = HOLD_W'(1);
        end else begin
          no_req_next = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_next       = GAP;
          grant_next       = 4'd0;
          grant_valid_next = 1'b0;
          ptr_next         = grant_id + 2'd1;
          timeout_next     = hit_limit & ~done & ~owner_drop;
        end else if (hold_cnt != {HOLD_W{1'b1}}) begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end else begin
          hold_cnt_next = hold_cnt;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next       = IDLE;
        grant_next       = 4'd0;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      grant       <= 4'd0;
      grant_id    <= 2'd0;
      grant_valid <= 1'b0;
      no_req      <= 1'b1;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      hold_cnt    <= hold_cnt_next;
      grant       <= grant_next;
      grant_id    <= grant_id_next;
      grant_valid <= grant_valid_next;
      no_req      <= no_req_next;
      timeout     <= timeout_next;
    end
  end

endmodule

// File: doc/rr_arbiter_4to2.md
Name: rr_arbiter_4to2

Overview:
- Four-requester arbiter that shares one downstream resource, such as a bus port or an engine.
- Selects one requester per tenure and drives a one-hot grant plus an encoded 2-bit grant index, in the 4-to-2 encoding style.
- Holds the grant until the owner releases it, drops its request, or hits a hold-time limit.
- Supports round-robin mode, or fixed-priority mode where bit 3 is highest.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = fixed priority, req[3] highest down to req[0].
- HOLD_MAX, 16: maximum tenure in cycles, 1..255. 0 means no limit.
- HOLD_W, 8: width of the hold counter. Must be wide enough to hold HOLD_MAX.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector, one bit per requester.
- done  input  1  release strobe from the current owner, sampled only in GRANT.
- grant  output  4  one-hot grant, registered.
- grant_id  output  2  encoded index of the granted requester. Valid when grant_valid=1.
- grant_valid  output  1  high while any grant is asserted.
- no_req  output  1  registered; 1 when in IDLE and req==0 was sampled.
- timeout  output  1  one-cycle pulse when a tenure is force-released by HOLD_MAX.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values (registers): grant=0, grant_id=0, grant_valid=0, no_req=1, timeout=0, state=IDLE, rr pointer ptr=0, hold counter=0.
- Reset mid-tenure: all outputs reach their reset values at the same edge. The pointer returns to 0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0 at edge k, a winner is chosen. At edge k, grant, grant_id and grant_valid are set, and the state moves to GRANT. Latency is 1 cycle from req to grant.
  - Round-robin winner: the first set bit scanning ptr, ptr+1, ... mod 4.
  - Fixed-priority winner: the highest set bit.
  - If req==0: stay in IDLE; no_req=1.
  - no_req=0 in every other case.
- GRANT:
  - The hold counter increments each cycle in GRANT. It starts at 1 in the first GRANT cycle.
  - Release happens when done=1, or req[grant_id]=0, or (HOLD_MAX!=0 and counter==HOLD_MAX).
  - On release: the next edge clears grant and grant_valid, moves to GAP, and sets ptr=grant_id+1 mod 4. ptr is updated in both modes but only used in round-robin.
  - grant_id keeps its last value after release.
- Timeout:
  - timeout pulses for exactly one cycle, in the GAP cycle.
  - It pulses only if HOLD_MAX was the release cause and neither done nor the request drop was also present.
  - If done or a request drop coincides with counter==HOLD_MAX, the release counts as normal: timeout=0.
- GAP:
  - One mandatory dead cycle with no grant, then unconditionally return to IDLE.
  - The next grant therefore appears no earlier than 2 cycles after the release edge.
- Signal rules:
  - done while in IDLE or GAP is ignored.
  - Changes to req other than the owner's bit during GRANT are ignored and do not preempt.
  - grant always equals the one-hot of grant_id whenever grant_valid=1.
  - grant is never multi-hot.
  - The grant is not shown combinationally.
- Counters:
  - The hold counter clears on entry to GRANT and saturates at its maximum. It never wraps.
  - ptr is a 2-bit counter and wraps 3 -> 0.

Test Plan:
- Reset with req=1111, FIXED_PRIORITY=0, then deassert reset:
  - First edge -> grant=0001, grant_id=0.
  - After done, one GAP cycle, then grant=0010, grant_id=1.
  - Then 0100 (id 2), then 1000 (id 3), then wraps to 0001 (id 0).
- FIXED_PRIORITY=1, req=0111, then req=1111 during GRANT of id 2:
  - The id 2 grant is held, with no preemption.
  - After done -> next grant=1000, grant_id=3.
- HOLD_MAX=4, req=0010 held, done=0:
  - grant=0010 for exactly 4 cycles.
  - Then grant=0 and timeout=1 for one cycle (GAP).
  - Then re-grant to id 1 on the next arbitration edge.
- Owner drops req[2] mid-tenure, req=0100 -> 0000:
  - Next edge grant=0, timeout=0.
  - GAP, then IDLE with no_req=1.
- done asserted on the same cycle the counter reaches HOLD_MAX=4:
  - Release with timeout=0.
- reset asserted during GRANT of id 3:
  - Next edge grant=0, grant_valid=0, no_req=1.
  - With req=1001 after reset -> grant=0001, because ptr was reset to 0.
